// File: rtl/hovertone_pkg.sv
// Shared constants for the hovertone phase sequencer: carrier timing, default sizes, FSM state codes.
package hovertone_pkg;

  localparam int unsigned CLK_FREQ   = 50_000_000;
  localparam int unsigned OUT_FREQ   = 40_000;
  localparam int unsigned PERIOD_CYC = CLK_FREQ / OUT_FREQ;

  localparam int unsigned DEF_NUM_CHANNELS = 4;
  localparam int unsigned DEF_PHASE_W      = 11;
  localparam int unsigned DEF_NUM_FRAMES   = 8;
  localparam int unsigned DEF_DWELL_W      = 16;

  localparam int unsigned ST_W = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

endpackage

// File: rtl/hovertone_frame_table.sv
// Phase/dwell frame storage: one synchronous write port, combinational full-frame read.
module hovertone_frame_table
  import hovertone_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int unsigned PHASE_W      = DEF_PHASE_W,
  parameter int unsigned NUM_FRAMES   = DEF_NUM_FRAMES,
  parameter int unsigned DWELL_W      = DEF_DWELL_W,
  localparam int unsigned FRAME_IW    = $clog2(NUM_FRAMES),
  localparam int unsigned CHAN_IW     = $clog2(NUM_CHANNELS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            we,
  input  logic                            dwell_we,
  input  logic [FRAME_IW-1:0]             wr_frame,
  input  logic [CHAN_IW-1:0]              wr_chan,
  input  logic [PHASE_W-1:0]              wr_phase,
  input  logic [DWELL_W-1:0]              wr_dwell,
  input  logic [FRAME_IW-1:0]             rd_frame,
  output logic [NUM_CHANNELS*PHASE_W-1:0] rd_phase_c,
  output logic [DWELL_W-1:0]              rd_dwell_c
);

  logic [PHASE_W-1:0] phase_q [NUM_FRAMES][NUM_CHANNELS];
  logic [DWELL_W-1:0] dwell_q [NUM_FRAMES];
  logic               frame_ok_c;
  logic               chan_ok_c;

  // Address guards only exist when the index range exceeds the array depth.
  generate
    if (NUM_FRAMES == (1 << FRAME_IW)) begin : g_frame_full
      assign frame_ok_c = 1'b1;
    end else begin : g_frame_part
      assign frame_ok_c = (wr_frame < FRAME_IW'(NUM_FRAMES));
    end
    if (NUM_CHANNELS == (1 << CHAN_IW)) begin : g_chan_full
      assign chan_ok_c = 1'b1;
    end else begin : g_chan_part
      assign chan_ok_c = (wr_chan < CHAN_IW'(NUM_CHANNELS));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int f = 0; f < int'(NUM_FRAMES); f++) begin
        dwell_q[f] <= '0;
        for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
          phase_q[f][c] <= '0;
        end
      end
    end else begin
      if (we && frame_ok_c && chan_ok_c) begin
        phase_q[wr_frame][wr_chan] <= wr_phase;
      end
      if (dwell_we && frame_ok_c) begin
        dwell_q[wr_frame] <= wr_dwell;
      end
    end
  end

  always_comb begin
    rd_phase_c = '0;
    for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
      rd_phase_c[c*PHASE_W +: PHASE_W] = phase_q[rd_frame][c];
    end
    rd_dwell_c = dwell_q[rd_frame];
  end

endmodule

// File: rtl/hovertone_phase_sequencer.sv
// Steps through phase frames on carrier-period boundaries. Optional HOVERTONE_SEQ_EXT_TRIG_EN
// adds ext_trig, gating every frame advance on a pending external trigger.
module hovertone_phase_sequencer
  import hovertone_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int unsigned PHASE_W      = DEF_PHASE_W,
  parameter int unsigned NUM_FRAMES   = DEF_NUM_FRAMES,
  parameter int unsigned DWELL_W      = DEF_DWELL_W,
  localparam int unsigned FRAME_IW    = $clog2(NUM_FRAMES),
  localparam int unsigned CHAN_IW     = $clog2(NUM_CHANNELS),
  localparam int unsigned BUS_W       = NUM_CHANNELS * PHASE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                period_tick,
  input  logic                cfg_we,
  input  logic                cfg_dwell_we,
  input  logic [FRAME_IW-1:0] cfg_frame,
  input  logic [CHAN_IW-1:0]  cfg_chan,
  input  logic [PHASE_W-1:0]  cfg_phase,
  input  logic [DWELL_W-1:0]  cfg_dwell,
  input  logic [FRAME_IW-1:0] last_frame,
  input  logic                loop_en,
  input  logic                start,
  input  logic                stop,
`ifdef HOVERTONE_SEQ_EXT_TRIG_EN
  input  logic                ext_trig,
`endif
  output logic                busy,
  output logic                done,
  output logic [FRAME_IW-1:0] frame_idx,
  output logic [BUS_W-1:0]    phase_out,
  output logic                phase_valid
);

  logic [ST_W-1:0]     state_q, state_d;
  logic [FRAME_IW-1:0] last_q, last_d, last_clamp_c;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [FRAME_IW-1:0] frame_idx_d;
  logic [BUS_W-1:0]    phase_d;
  logic                busy_d, done_d, valid_d;
  logic                apply_c;
  logic [FRAME_IW-1:0] apply_idx_c;
  logic [BUS_W-1:0]    rd_phase_c;
  logic [DWELL_W-1:0]  rd_dwell_c;
  logic                trig_ok_c;

  hovertone_frame_table #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .PHASE_W      (PHASE_W),
    .NUM_FRAMES   (NUM_FRAMES),
    .DWELL_W      (DWELL_W)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .we         (cfg_we),
    .dwell_we   (cfg_dwell_we),
    .wr_frame   (cfg_frame),
    .wr_chan    (cfg_chan),
    .wr_phase   (cfg_phase),
    .wr_dwell   (cfg_dwell),
    .rd_frame   (apply_idx_c),
    .rd_phase_c (rd_phase_c),
    .rd_dwell_c (rd_dwell_c)
  );

  generate
    if (NUM_FRAMES == (1 << FRAME_IW)) begin : g_last_full
      assign last_clamp_c = last_frame;
    end else begin : g_last_clamp
      assign last_clamp_c = (last_frame > FRAME_IW'(NUM_FRAMES - 1)) ?
                            FRAME_IW'(NUM_FRAMES - 1) : last_frame;
    end
  endgenerate

`ifdef HOVERTONE_SEQ_EXT_TRIG_EN
  logic trig_pend_q;

  // Sticky trigger, consumed by each applied frame.
  always_ff @(posedge clk) begin
    if (rst || stop) begin
      trig_pend_q <= 1'b0;
    end else if (apply_c) begin
      trig_pend_q <= 1'b0;
    end else if (ext_trig) begin
      trig_pend_q <= 1'b1;
    end
  end

  assign trig_ok_c = trig_pend_q | ext_trig;
`else
  assign trig_ok_c = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    dwell_d     = dwell_q;
    frame_idx_d = frame_idx;
    phase_d     = phase_out;
    done_d      = 1'b0;
    valid_d     = 1'b0;
    apply_c     = 1'b0;
    apply_idx_c = '0;

    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d     = ST_ARM;
            frame_idx_d = '0;
            last_d      = last_clamp_c;
          end
        end
        ST_ARM: begin
          if (period_tick) begin
            apply_c = 1'b1;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (period_tick) begin
            if (dwell_q != '0) begin
              dwell_d = dwell_q - DWELL_W'(1);
            end else if (trig_ok_c) begin
              if (frame_idx != last_q) begin
                apply_c     = 1'b1;
                apply_idx_c = frame_idx + FRAME_IW'(1);
              end else if (loop_en) begin
                apply_c = 1'b1;
              end else begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Table read happens before any same-cycle write lands, so the old value is applied.
    if (apply_c) begin
      frame_idx_d = apply_idx_c;
      phase_d     = rd_phase_c;
      dwell_d     = (rd_dwell_c == '0) ? '0 : rd_dwell_c - DWELL_W'(1);
      valid_d     = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q      <= '0;
      dwell_q     <= '0;
      frame_idx   <= '0;
      phase_out   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      phase_valid <= 1'b0;
    end else begin
      last_q      <= last_d;
      dwell_q     <= dwell_d;
      frame_idx   <= frame_idx_d;
      phase_out   <= phase_d;
      busy        <= busy_d;
      done        <= done_d;
      phase_valid <= valid_d;
    end
  end

endmodule
